// File: rtl/alu_seq_hs_pkg.sv
// Shared opcode and state definitions for the handshaked sequential ALU.
package alu_seq_hs_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Only MUL takes the multi-cycle path; everything else completes on accept.
  function automatic logic op_is_mul(input logic [2:0] op);
    return (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_seq_hs_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle.
// done marks the cycle whose step completes the product; product carries
// the completed value during that cycle so the caller can register it.
module alu_seq_mul #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  logic [2*N-1:0] acc_r;
  logic [2*N-1:0] addend_s;
  logic [CW-1:0]  cnt_r;
  logic           busy_r;
  logic [N-1:0]   b_shift_s;

  // Partial product for the current step: A weighted by 2^cnt when B[cnt] is set.
  always_comb begin
    b_shift_s = B >> cnt_r;
    if (b_shift_s[0]) begin
      addend_s = {{N{1'b0}}, A} << cnt_r;
    end else begin
      addend_s = {(2*N){1'b0}};
    end
  end

  assign product = acc_r + addend_s;
  assign done    = busy_r && (cnt_r == LAST_STEP);
  assign busy    = busy_r;

  // Accumulator and step counter; start clears them, each busy cycle adds one step.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_r  <= {(2*N){1'b0}};
      cnt_r  <= {CW{1'b0}};
      busy_r <= 1'b0;
    end else if (start) begin
      acc_r  <= {(2*N){1'b0}};
      cnt_r  <= {CW{1'b0}};
      busy_r <= 1'b1;
    end else if (busy_r) begin
      acc_r  <= product;
      cnt_r  <= cnt_r + CW'(1);
      busy_r <= !done;
    end else begin
      acc_r  <= acc_r;
      cnt_r  <= cnt_r;
      busy_r <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_hs.sv
// Clocked 8-op ALU with valid/ready on both sides and an iterative multiply.
module alu_seq_hs
  import alu_seq_hs_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   opcode,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         carry,
  output logic         ovf,
  output logic         zero,
  output logic         out_valid,
  input  logic         out_ready
);

  state_e         state_r, state_s;
  logic [N-1:0]   op_a_r, op_b_r;
  logic [2:0]     op_r;
  logic [N-1:0]   result_r, result_hi_r;
  logic           carry_r, ovf_r, zero_r;
  logic           in_ready_r, out_valid_r;
  logic           accept_s, mul_start_s, mul_capture_s;
  logic           mul_busy_s, mul_done_s;
  logic [2*N-1:0] mul_product_s;
  logic [N:0]     sum_s, dif_s;
  logic [N-1:0]   alu_lo_s;
  logic           alu_carry_s, alu_ovf_s;

  alu_seq_mul #(.N(N), .CW(CW)) u_mul (
    .CLK     (CLK),
    .RST     (RST),
    .start   (mul_start_s),
    .A       (op_a_r),
    .B       (op_b_r),
    .busy    (mul_busy_s),
    .done    (mul_done_s),
    .product (mul_product_s)
  );

  // Single-cycle datapath straight from the inputs so the result lands on the accept edge.
  always_comb begin
    sum_s       = {1'b0, A} + {1'b0, B};
    dif_s       = {1'b0, A} - {1'b0, B};
    alu_lo_s    = {N{1'b0}};
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_lo_s    = sum_s[N-1:0];
        alu_carry_s = sum_s[N];
        alu_ovf_s   = (A[N-1] == B[N-1]) && (sum_s[N-1] != A[N-1]);
      end
      OP_SUB: begin
        alu_lo_s    = dif_s[N-1:0];
        alu_carry_s = dif_s[N];
        alu_ovf_s   = (A[N-1] != B[N-1]) && (dif_s[N-1] != A[N-1]);
      end
      OP_AND: alu_lo_s = A & B;
      OP_OR:  alu_lo_s = A | B;
      OP_XOR: alu_lo_s = A ^ B;
      // Shift amounts of N or more shift every bit out, giving 0.
      OP_SHL: alu_lo_s = A << B;
      OP_SHR: alu_lo_s = A >> B;
      OP_MUL: alu_lo_s = {N{1'b0}};
      default: alu_lo_s = {N{1'b0}};
    endcase
  end

  // Next-state and handshake decode for IDLE / EXEC / DONE.
  always_comb begin
    state_s       = state_r;
    accept_s      = 1'b0;
    mul_start_s   = 1'b0;
    mul_capture_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          if (op_is_mul(opcode)) begin
            mul_start_s = 1'b1;
            state_s     = S_EXEC;
          end else begin
            state_s = S_DONE;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_EXEC: begin
        if (mul_done_s && op_is_mul(op_r)) begin
          mul_capture_s = 1'b1;
          state_s       = S_DONE;
        end else if (mul_busy_s) begin
          state_s = S_EXEC;
        end else begin
          // Multiplier idle without finishing: recover rather than hang.
          state_s = S_IDLE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register plus registered handshake outputs decoded from the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == S_IDLE);
      out_valid_r <= (state_s == S_DONE);
    end
  end

  // Operand capture and result/flag registers, held untouched while in DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_a_r      <= {N{1'b0}};
      op_b_r      <= {N{1'b0}};
      op_r        <= 3'd0;
      result_r    <= {N{1'b0}};
      result_hi_r <= {N{1'b0}};
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        op_a_r <= A;
        op_b_r <= B;
        op_r   <= opcode;
      end
      if (accept_s && !mul_start_s) begin
        result_r    <= alu_lo_s;
        result_hi_r <= {N{1'b0}};
        carry_r     <= alu_carry_s;
        ovf_r       <= alu_ovf_s;
        zero_r      <= (alu_lo_s == {N{1'b0}});
      end else if (mul_capture_s) begin
        result_r    <= mul_product_s[N-1:0];
        result_hi_r <= mul_product_s[2*N-1:N];
        carry_r     <= 1'b0;
        ovf_r       <= 1'b0;
        zero_r      <= (mul_product_s == {(2*N){1'b0}});
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign result_hi = result_hi_r;
  assign carry     = carry_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule
